// File: rtl/multicycle_add_pkg.sv
// Shared types and helpers for the slice-serial adder sequencer.
package multicycle_add_pkg;

  // Sequencer states: waiting for operands, stepping slices, holding result.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } add_state_t;

  // Width of the slice index. It is at least one bit so that NSL==1 still
  // yields a legal vector.
  function automatic int idx_width(input int nsl);
    return (nsl > 1) ? $clog2(nsl) : 1;
  endfunction

endpackage : multicycle_add_pkg

// File: rtl/ripple_carry_adder.sv
// SIZE-bit ripple-carry adder. Cout exposes the carry out of every bit
// position, so Cout[SIZE-1] is the carry out of the whole slice.
module ripple_carry_adder #(
  parameter int SIZE = 8
) (
  input  logic [SIZE-1:0] A,
  input  logic [SIZE-1:0] B,
  input  logic            Cin,
  output logic [SIZE-1:0] S,
  output logic [SIZE-1:0] Cout
);

  // Bit-serial carry chain, evaluated LSB to MSB.
  always_comb begin
    logic c;
    // NOTE: every variable assigned in always_comb gets a default on entry;
    // a path that leaves one unassigned would infer a latch.
    S    = '0;
    Cout = '0;
    c    = Cin;
    for (int i = 0; i < SIZE; i++) begin
      S[i]    = A[i] ^ B[i] ^ c;
      Cout[i] = (A[i] & B[i]) | (c & (A[i] ^ B[i]));
      c       = Cout[i];
    end
  end

endmodule : ripple_carry_adder

// File: rtl/multicycle_add_ctrl.sv
// Slice-serial WIDTH-bit adder. One SLICE-bit ripple_carry_adder is reused
// for WIDTH/SLICE cycles, LSB slice first. A registered carry links each
// slice to the next. Operands come in on a valid/ready handshake, and the
// sum/cout go out on another.
module multicycle_add_ctrl
  import multicycle_add_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  // Guard the divisor so a bad SLICE reaches the $error below instead of
  // failing on a division by zero.
  localparam int SLICE_SAFE = (SLICE >= 1) ? SLICE : 1;
  localparam bit PARAM_OK   = (SLICE >= 1) && (WIDTH >= SLICE) &&
                              ((WIDTH % SLICE_SAFE) == 0);
  localparam int NSL        = PARAM_OK ? (WIDTH / SLICE_SAFE) : 1;
  localparam int IDX_W      = idx_width(NSL);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSL - 1);

  if (!PARAM_OK) begin : g_param_err
    $error("multicycle_add_ctrl: WIDTH (%0d) must be a non-zero multiple of SLICE (%0d)",
           WIDTH, SLICE);
  end

  add_state_t       state_q, state_d;
  logic [IDX_W-1:0] idx_q;
  logic             carry_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;

  logic             accept;
  logic             in_run;
  logic             run_last;

  logic [SLICE-1:0] a_slice, b_slice, s_slice, c_vec;
  logic             slice_carry;
  logic             unused_low_carries;

  assign accept   = in_valid && (state_q == IDLE);
  assign in_run   = (state_q == RUN);
  assign run_last = in_run && (idx_q == LAST_IDX);

  // Select the operand slice for the current step. idx_q never exceeds
  // NSL-1, so the part-select always stays in range.
  assign a_slice = a_q[int'(idx_q) * SLICE +: SLICE];
  assign b_slice = b_q[int'(idx_q) * SLICE +: SLICE];

  ripple_carry_adder #(
    .SIZE (SLICE)
  ) u_rca (
    .A    (a_slice),
    .B    (b_slice),
    .Cin  (carry_q),
    .S    (s_slice),
    .Cout (c_vec)
  );

  // Only the carry out of the top bit of the slice continues the chain.
  assign slice_carry        = c_vec[SLICE-1];
  assign unused_low_carries = &{1'b0, c_vec};

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state is assigned with <= so every register samples
    // the values from before the edge, independent of statement order.
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: accept -> step NSL slices -> hold until consumed.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid)  state_d = RUN;
      RUN:     if (run_last)  state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  // Handshake and status outputs decoded from the state.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    unique case (state_q)
      IDLE:    in_ready = 1'b1;
      RUN:     busy     = 1'b1;
      DONE: begin
        out_valid = 1'b1;
        busy      = 1'b1;
      end
      default: ;
    endcase
  end

  // Operand capture on accept, so a and b are free to change afterwards.
  always_ff @(posedge clk) begin
    // NOTE: the operand registers are data only. Nothing reads them
    // outside RUN, and RUN is only reached through a load, so they are
    // left without a reset.
    if (accept) begin
      a_q <= a;
      b_q <= b;
    end
  end

  // Slice sequencing: carry chain, slice index, sum assembly and final cout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q   <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else if (accept) begin
      idx_q   <= '0;
      carry_q <= cin;
    end else if (in_run) begin
      sum_q[int'(idx_q) * SLICE +: SLICE] <= s_slice;
      carry_q                             <= slice_carry;
      if (idx_q == LAST_IDX) begin
        cout_q <= slice_carry;
      end else begin
        idx_q <= idx_q + 1'b1;
      end
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;

endmodule : multicycle_add_ctrl
